chip8_pace_ctrl: RTL and testbench

Schedules CHIP-8 CPU execution strobes and the 60 Hz delay/sound-timer strobe from the 60 MHz system clock. It owns the speed-select policy and applies rate changes only at instruction boundaries. It supports pause and single-step for the OSD, and absorbs CPU stalls (e.g. DRAW waiting on the framebuffer) without losing ticks. It replaces ad-hoc clock-enable gating feeding the CPU core; all outputs are clock enables in the `clk` domain, never gated clocks.

---
 rtl/chip8_clk_pkg.sv | 35 +++
 rtl/chip8_pace_ctrl_ce_divider.sv | 48 ++++
 rtl/chip8_pace_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_chip8_pace_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_clk_pkg.sv
// Shared types and constants for the CHIP-8 pacing controller.
package chip8_clk_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2
  } state_e;

  // CPU speed codes as seen on clksel / rate_cur
  typedef enum logic [1:0] {
    RATE_5K  = 2'd0,
    RATE_10K = 2'd1,
    RATE_15K = 2'd2,
    RATE_20K = 2'd3
  } rate_e;

  // Divisors for a 60 MHz system clock
  localparam int unsigned DEF_DIV0      = 32'd12000;
  localparam int unsigned DEF_DIV1      = 32'd6000;
  localparam int unsigned DEF_DIV2      = 32'd4000;
  localparam int unsigned DEF_DIV3      = 32'd3000;
  localparam int unsigned DEF_TIMER_DIV = 32'd1000000;

  // Counter widths
  localparam int unsigned CPU_CNT_W = 32'd14;
  localparam int unsigned TMR_CNT_W = $clog2(DEF_TIMER_DIV);

  // Width needed to count 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chip8_pace_ctrl_ce_divider.sv
// Free-running modulo-N counter producing a one-cycle wrap indication.
// The divisor is latched on load so a new rate only takes effect for the
// interval that starts after the current one ends.
module ce_divider #(
  parameter int unsigned W       = 32'd14,
  parameter int unsigned RST_DIV = 32'd12000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div_in,
  output logic         wrap
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] div_r;
  logic         at_end_s;

  assign at_end_s = (cnt_r == (div_r - W'(1'b1)));
  assign wrap     = en & at_end_s;

  // Divisor latch, reloaded only when the owner says an interval boundary is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= W'(RST_DIV);
    end else if (load) begin
      div_r <= div_in;
    end else begin
      div_r <= div_r;
    end
  end

  // Count 0..div-1 while enabled; clear has priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      cnt_r <= at_end_s ? {W{1'b0}} : (cnt_r + W'(1'b1));
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/chip8_pace_ctrl.sv
// CHIP-8 execution pacer: CPU and 60 Hz timer clock enables with rate
// select, pause/single-step, and stall absorption with overrun counting.
module chip8_pace_ctrl
  import chip8_clk_pkg::*;
#(
  parameter int unsigned DIV0      = DEF_DIV0,
  parameter int unsigned DIV1      = DEF_DIV1,
  parameter int unsigned DIV2      = DEF_DIV2,
  parameter int unsigned DIV3      = DEF_DIV3,
  parameter int unsigned TIMER_DIV = DEF_TIMER_DIV
) (
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] clksel,
  input  logic       pause,
  input  logic       step_req,
  input  logic       cpu_stall,
  input  logic       ovr_clr,
  output logic       cpu_ce,
  output logic       timer_ce,
  output logic       paused,
  output logic [1:0] rate_cur,
  output logic [7:0] ovr_cnt
);

  localparam int unsigned TMR_W = cnt_width(TIMER_DIV);

  state_e                 state_r;
  state_e                 state_s;
  logic                   pend_r;
  logic                   pend_s;
  logic                   ce_s;
  logic                   ovr_inc_s;
  logic                   cpu_ce_r;
  logic                   timer_ce_r;
  logic                   paused_r;
  logic [1:0]             rate_cur_r;
  logic [7:0]             ovr_r;
  logic                   run_go_s;
  logic                   tick_due_s;
  logic                   tmr_wrap_s;
  logic                   enter_run_s;
  logic                   load_s;
  logic                   can_issue_s;
  logic [CPU_CNT_W-1:0]   div_sel_s;

  // Counting happens only in RUN and not in the cycle pause is taken,
  // so a tick due on that edge is suppressed.
  assign run_go_s    = (state_r == ST_RUN) & ~pause;
  assign enter_run_s = (state_r != ST_RUN) & (state_s == ST_RUN);
  assign load_s      = tick_due_s | enter_run_s;
  // A tick may only go out if the CPU accepts it and the previous cycle was
  // not already an enable, keeping cpu_ce strictly single-cycle.
  assign can_issue_s = ~cpu_stall & ~cpu_ce_r;

  ce_divider #(
    .W       (CPU_CNT_W),
    .RST_DIV (DIV0)
  ) u_cpu_div (
    .clk    (clk),
    .rst    (res),
    .clr    (~run_go_s),
    .en     (run_go_s),
    .load   (load_s),
    .div_in (div_sel_s),
    .wrap   (tick_due_s)
  );

  ce_divider #(
    .W       (TMR_W),
    .RST_DIV (TIMER_DIV)
  ) u_tmr_div (
    .clk    (clk),
    .rst    (res),
    .clr    (1'b0),
    .en     (run_go_s),
    .load   (1'b0),
    .div_in (TMR_W'(TIMER_DIV)),
    .wrap   (tmr_wrap_s)
  );

  // Divisor for the requested rate, latched only at interval boundaries
  always_comb begin
    div_sel_s = CPU_CNT_W'(DIV0);
    case (rate_e'(clksel))
      RATE_5K:  div_sel_s = CPU_CNT_W'(DIV0);
      RATE_10K: div_sel_s = CPU_CNT_W'(DIV1);
      RATE_15K: div_sel_s = CPU_CNT_W'(DIV2);
      RATE_20K: div_sel_s = CPU_CNT_W'(DIV3);
      default:  div_sel_s = CPU_CNT_W'(DIV0);
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, tick issue, pending and overrun decisions
  always_comb begin
    state_s   = state_r;
    ce_s      = 1'b0;
    pend_s    = pend_r;
    ovr_inc_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (pause) begin
          state_s = ST_PAUSE;
          pend_s  = 1'b0;
        end else if (tick_due_s) begin
          if (can_issue_s) begin
            // With a tick already pending, the new tick replaces the one consumed
            ce_s = 1'b1;
          end else if (pend_r) begin
            ovr_inc_s = 1'b1;
          end else begin
            pend_s = 1'b1;
          end
        end else if (pend_r && can_issue_s) begin
          ce_s   = 1'b1;
          pend_s = 1'b0;
        end else begin
          ce_s = 1'b0;
        end
      end
      ST_PAUSE: begin
        pend_s = 1'b0;
        if (!pause) begin
          state_s = ST_RUN;
        end else if (step_req) begin
          state_s = ST_STEP;
          ce_s    = ~cpu_stall;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_STEP: begin
        pend_s = 1'b0;
        if (cpu_ce_r) begin
          state_s = pause ? ST_PAUSE : ST_RUN;
        end else if (!cpu_stall) begin
          ce_s = 1'b1;
        end else begin
          ce_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_RUN;
        pend_s  = 1'b0;
      end
    endcase
  end

  // Registered enables, status, rate latch, pending flag and overrun counter
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cpu_ce_r   <= 1'b0;
      timer_ce_r <= 1'b0;
      paused_r   <= 1'b0;
      rate_cur_r <= 2'd0;
      pend_r     <= 1'b0;
      ovr_r      <= 8'd0;
    end else begin
      cpu_ce_r   <= ce_s;
      timer_ce_r <= tmr_wrap_s;
      paused_r   <= (state_s != ST_RUN);
      pend_r     <= pend_s;
      rate_cur_r <= load_s ? clksel : rate_cur_r;
      if (ovr_clr) begin
        ovr_r <= 8'd0;
      end else if (ovr_inc_s && (ovr_r != 8'hFF)) begin
        ovr_r <= ovr_r + 8'd1;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  assign cpu_ce   = cpu_ce_r;
  assign timer_ce = timer_ce_r;
  assign paused   = paused_r;
  assign rate_cur = rate_cur_r;
  assign ovr_cnt  = ovr_r;

endmodule

// File: tb/tb_chip8_pace_ctrl.sv
// Directed bench for chip8_pace_ctrl with small divisors.
module tb_chip8_pace_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [1:0] clksel = 2'd0;
  logic       pause = 1'b0;
  logic       step_req = 1'b0;
  logic       cpu_stall = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       cpu_ce;
  logic       timer_ce;
  logic       paused;
  logic [1:0] rate_cur;
  logic [7:0] ovr_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_ce = 0;
  int n_tce = 0;

  typedef struct {
    bit         rst;
    int         cyc;
    logic [1:0] sel;
    logic       p;
    logic       st;
    logic       clr;
    logic       e_ce;
    logic       e_tce;
    logic       e_p;
    bit         chk_rate;
    logic [1:0] e_rate;
    logic [7:0] e_ovr;
    int         e_nce;
    int         e_ntce;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  always #5 clk = ~clk;

  chip8_pace_ctrl #(
    .DIV0(12), .DIV1(6), .DIV2(4), .DIV3(3), .TIMER_DIV(20)
  ) dut (
    .clk(clk), .res(res), .clksel(clksel), .pause(pause),
    .step_req(step_req), .cpu_stall(cpu_stall), .ovr_clr(ovr_clr),
    .cpu_ce(cpu_ce), .timer_ce(timer_ce), .paused(paused),
    .rate_cur(rate_cur), .ovr_cnt(ovr_cnt)
  );

  function automatic vec_t mk(input bit rst, input int c, input logic [1:0] sel,
                              input logic p, input logic st, input logic clr,
                              input logic e_ce, input logic e_tce, input logic e_p,
                              input bit cr, input logic [1:0] e_rate,
                              input logic [7:0] e_ovr, input int nce, input int ntce);
    vec_t r;
    r.rst = rst; r.cyc = c; r.sel = sel; r.p = p; r.st = st; r.clr = clr;
    r.e_ce = e_ce; r.e_tce = e_tce; r.e_p = e_p; r.chk_rate = cr;
    r.e_rate = e_rate; r.e_ovr = e_ovr; r.e_nce = nce; r.e_ntce = ntce;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_ce === 1'b1) n_ce++;
    if (timer_ce === 1'b1) n_tce++;
  endtask

  task automatic do_reset();
    res = 1'b1; clksel = 2'd0; pause = 1'b0; step_req = 1'b0;
    cpu_stall = 1'b0; ovr_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    res = 1'b0; cyc = 0; n_ce = 0; n_tce = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rst cyc sel p st clr | ce tce paused chkrate rate ovr nce ntce
    // Run at rate 0: ticks every 12, timer every 20
    vecs.push_back(mk(1, 11, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 12, 2'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 20, 2'd0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 8'd0, 1, 1));
    vecs.push_back(mk(0, 24, 2'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd0, 2, 1));
    vecs.push_back(mk(0, 36, 2'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd0, 3, 1));
    vecs.push_back(mk(0, 40, 2'd0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 8'd0, 3, 2));
    vecs.push_back(mk(0, 48, 2'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd0, 4, 2));
    vecs.push_back(mk(0, 50, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd0, 4, 2));
    // Rate 0 -> 3 requested at cycle 5: interval to 12 is kept, then every 3
    vecs.push_back(mk(1,  5, 2'd3, 0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 11, 2'd3, 0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 12, 2'd3, 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 13, 2'd3, 0, 0, 0, 0, 0, 0, 1, 2'd3, 8'd0, 1, 0));
    vecs.push_back(mk(0, 15, 2'd3, 0, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0, 2, 0));
    vecs.push_back(mk(0, 18, 2'd3, 0, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0, 3, 0));
    vecs.push_back(mk(0, 19, 2'd3, 0, 0, 0, 0, 0, 0, 1, 2'd3, 8'd0, 3, 0));
    // Stall across two ticks, release at 30, clear overrun at 32
    vecs.push_back(mk(1,  5, 2'd0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 12, 2'd0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 20, 2'd0, 0, 1, 0, 0, 1, 0, 1, 2'd0, 8'd0, 0, 1));
    vecs.push_back(mk(0, 24, 2'd0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 30, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 31, 2'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd1, 1, 1));
    vecs.push_back(mk(0, 32, 2'd0, 0, 0, 1, 0, 0, 0, 1, 2'd0, 8'd1, 1, 1));
    vecs.push_back(mk(0, 33, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 8'd0, 1, 1));
    vecs.push_back(mk(0, 36, 2'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 8'd0, 2, 1));
    vecs.push_back(mk(0, 40, 2'd0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 8'd0, 2, 2));

    // Reset state while res is held
    #3;
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_timer_ce", timer_ce, 0);
    chk("rst_paused", paused, 0);
    chk("rst_rate_cur", rate_cur, 0);
    chk("rst_ovr_cnt", ovr_cnt, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      for (int k = 0; k < 2000 && cyc < v.cyc; k++) step();
      chk($sformatf("vec%0d_cpu_ce", i), cpu_ce, v.e_ce);
      chk($sformatf("vec%0d_timer_ce", i), timer_ce, v.e_tce);
      chk($sformatf("vec%0d_paused", i), paused, v.e_p);
      if (v.chk_rate) chk($sformatf("vec%0d_rate_cur", i), rate_cur, v.e_rate);
      chk($sformatf("vec%0d_ovr_cnt", i), ovr_cnt, v.e_ovr);
      chk($sformatf("vec%0d_ce_count", i), n_ce, v.e_nce);
      chk($sformatf("vec%0d_tce_count", i), n_tce, v.e_ntce);
      clksel = v.sel; pause = v.p; cpu_stall = v.st; ovr_clr = v.clr;
    end

    // Pause for 100 cycles, then single-step twice, then resume
    do_reset();
    repeat (5) step();
    pause = 1'b1;
    step();
    chk("pause_paused_rise", paused, 1);
    repeat (100) step();
    chk("pause_no_ce", n_ce, 0);
    chk("pause_no_tce", n_tce, 0);
    chk("pause_paused_hold", paused, 1);
    step_req = 1'b1; step(); step_req = 1'b0;
    chk("step1_ce", cpu_ce, 1);
    step();
    chk("step1_ce_drop", cpu_ce, 0);
    chk("step1_paused", paused, 1);
    repeat (5) step();
    chk("step1_count", n_ce, 1);
    step_req = 1'b1; step(); step_req = 1'b0;
    chk("step2_ce", cpu_ce, 1);
    repeat (3) step();
    chk("step2_count", n_ce, 2);
    pause = 1'b0;
    step();
    chk("resume_paused_fall", paused, 0);
    repeat (11) step();
    chk("resume_no_early_ce", n_ce, 2);
    step();
    chk("resume_first_ce", cpu_ce, 1);

    // Step request while stalled; a second request during STEP is ignored
    do_reset();
    pause = 1'b1; cpu_stall = 1'b1;
    repeat (3) step();
    chk("sstep_paused", paused, 1);
    step_req = 1'b1; step(); step_req = 1'b0;
    chk("sstep_held", cpu_ce, 0);
    step();
    step_req = 1'b1; step(); step_req = 1'b0;
    step(); step();
    chk("sstep_held_count", n_ce, 0);
    cpu_stall = 1'b0;
    step();
    chk("sstep_release_ce", cpu_ce, 1);
    step();
    chk("sstep_ce_drop", cpu_ce, 0);
    chk("sstep_back_paused", paused, 1);
    repeat (4) step();
    chk("sstep_single", n_ce, 1);
    step_req = 1'b1; step(); step_req = 1'b0;
    chk("sstep_again_ce", cpu_ce, 1);
    repeat (2) step();
    chk("sstep_again_count", n_ce, 2);

    // Overrun saturation, then clear coinciding with an increment
    do_reset();
    clksel = 2'd3; cpu_stall = 1'b1;
    for (int k = 0; k < 2000 && cyc < 803; k++) step();
    chk("sat_ovr_cnt", ovr_cnt, 255);
    chk("sat_no_ce", n_ce, 0);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("clr_wins", ovr_cnt, 0);
    repeat (3) step();
    chk("clr_then_inc", ovr_cnt, 1);

    // Reset mid-operation with pending tick and ovr_cnt = 3
    do_reset();
    clksel = 2'd2; cpu_stall = 1'b1;
    for (int k = 0; k < 100 && cyc < 24; k++) step();
    chk("pre_rst_ovr", ovr_cnt, 3);
    chk("pre_rst_rate", rate_cur, 2);
    chk("pre_rst_no_ce", n_ce, 0);
    res = 1'b1;
    #1;
    chk("mid_rst_cpu_ce", cpu_ce, 0);
    chk("mid_rst_timer_ce", timer_ce, 0);
    chk("mid_rst_paused", paused, 0);
    chk("mid_rst_rate", rate_cur, 0);
    chk("mid_rst_ovr", ovr_cnt, 0);
    @(posedge clk);
    #1;
    cpu_stall = 1'b0; clksel = 2'd0; res = 1'b0;
    cyc = 0; n_ce = 0; n_tce = 0;
    repeat (11) step();
    chk("post_rst_no_early_ce", n_ce, 0);
    step();
    chk("post_rst_first_ce", cpu_ce, 1);
    chk("post_rst_ce_count", n_ce, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
